// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
//
// Parametrised multi-port register file with an integrated pending-write
// scoreboard. Decode reads operands and marks destinations busy at issue;
// write-back stores results and clears the busy bit. Read ports see a
// same-cycle write-back through a bypass, so a consumer waiting on a RAW
// hazard becomes ready in the very cycle its producer writes back.
//
// Parameters
//   DW   data width in bits
//   AW   address width; depth = 2**AW registers
//   NRP  number of read ports (>= 1)
//
// Ports
//   clk         rising-edge clock for all state
//   rst_n       asynchronous active-low reset
//   rd_addr     NRP packed read addresses, port i at [i*AW +: AW]
//   rd_data     NRP packed read data, port i at [i*DW +: DW] (combinational)
//   rd_rdy      per-port: data is valid, i.e. register not pending
//   wb_en       write-back enable
//   wb_addr     write-back address
//   wb_data     write-back data
//   issue_en    request to mark issue_addr busy
//   issue_addr  destination register of the issuing instruction
//   issue_rdy   issue request would be accepted this cycle (ignores issue_en)
//   pend_cnt    registered count of busy registers (0 .. 2**AW)
//   wb_err      sticky flag: a write-back hit a register that was not busy
// -----------------------------------------------------------------------------
module reg_file_sb #(
  parameter int DW  = 32,
  parameter int AW  = 4,
  parameter int NRP = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRP*AW-1:0] rd_addr,
  output logic [NRP*DW-1:0] rd_data,
  output logic [NRP-1:0]    rd_rdy,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DW-1:0]     wb_data,
  input  logic              issue_en,
  input  logic [AW-1:0]     issue_addr,
  output logic              issue_rdy,
  output logic [AW:0]       pend_cnt,
  output logic              wb_err
);

  localparam int DEPTH = 2 ** AW;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DW-1:0]    regs_q [DEPTH];
  logic [DW-1:0]    regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [AW:0]      pend_cnt_q;
  logic [AW:0]      pend_cnt_d;
  logic             wb_err_q;
  logic             wb_err_d;

  // Handshake terms shared by next-state logic.
  logic issue_acc;   // issue accepted on this edge
  logic same_addr;   // accepted issue targets the register being written back
  logic busy_set;    // accepted issue turns a clear busy bit on
  logic busy_clr;    // write-back turns a set busy bit off

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  // Each port is independent; a write-back to the addressed register wins over
  // storage and is always ready, even if the register is still marked busy.
  // While reset is asserted the outputs are forced to their reset view so a
  // live wb_en cannot leak through the bypass.
  for (genvar i = 0; i < NRP; i++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit;

    assign addr = rd_addr[i*AW +: AW];
    assign hit  = wb_en && (wb_addr == addr);

    assign rd_data[i*DW +: DW] = !rst_n ? '0
                               : hit    ? wb_data
                               :          regs_q[addr];
    assign rd_rdy[i]           = !rst_n || hit || !busy_q[addr];
  end

  // ---------------------------------------------------------------------------
  // Issue handshake
  // ---------------------------------------------------------------------------
  // A busy destination may still issue when its write-back lands in the same
  // cycle: the write retires the old producer and the new one takes over.
  assign issue_rdy = !rst_n || !busy_q[issue_addr]
                  || (wb_en && (wb_addr == issue_addr));
  assign issue_acc = issue_en && issue_rdy;
  assign same_addr = issue_acc && (issue_addr == wb_addr);

  // Count deltas are taken from actual busy-bit transitions so pend_cnt always
  // equals the population count of busy, including the same-address case.
  assign busy_set  = issue_acc && !busy_q[issue_addr];
  assign busy_clr  = wb_en && busy_q[wb_addr] && !same_addr;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block is given its hold value before any
  // conditional update, so no path leaves a variable unassigned (no latches).
  always_comb begin
    regs_d     = regs_q;
    busy_d     = busy_q;
    wb_err_d   = wb_err_q;
    pend_cnt_d = pend_cnt_q + (AW+1)'(busy_set) - (AW+1)'(busy_clr);

    if (wb_en) begin
      regs_d[wb_addr] = wb_data;
      busy_d[wb_addr] = 1'b0;
      // A write-back nobody was waiting for is a protocol error; data is
      // still stored so software-visible state stays deterministic.
      if (!busy_q[wb_addr] && !same_addr) begin
        wb_err_d = 1'b1;
      end
    end

    // Applied after the write-back so a same-address issue keeps busy set.
    if (issue_acc) begin
      busy_d[issue_addr] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: the storage array is reset along with the control state because
  // reads must return zero for every register after reset; this is a flop
  // array, not an SRAM macro, so a full reset is both legal and required.
  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // their _d values from the same pre-edge state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= '0;
      end
      busy_q     <= '0;
      pend_cnt_q <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= regs_d[r];
      end
      busy_q     <= busy_d;
      pend_cnt_q <= pend_cnt_d;
      wb_err_q   <= wb_err_d;
    end
  end

  assign pend_cnt = pend_cnt_q;
  assign wb_err   = wb_err_q;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  // The incremental counter must track the busy vector exactly.
  a_pend_matches_busy : assert property (
    @(posedge clk) disable iff (!rst_n) pend_cnt_q == ($countones(busy_q))
  );

endmodule

// File: tb/tb_reg_file_sb.sv
`timescale 1ns/1ps
module tb_reg_file_sb;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int NRP   = 3;
  localparam int DEPTH = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NRP*AW-1:0] rd_addr;
  logic [NRP*DW-1:0] rd_data;
  logic [NRP-1:0]    rd_rdy;
  logic              wb_en;
  logic [AW-1:0]     wb_addr;
  logic [DW-1:0]     wb_data;
  logic              issue_en;
  logic [AW-1:0]     issue_addr;
  logic              issue_rdy;
  logic [AW:0]       pend_cnt;
  logic              wb_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural contents, busy flags, sticky error.
  logic [DW-1:0] m_reg  [DEPTH];
  bit            m_busy [DEPTH];
  bit            m_err;

  reg_file_sb #(.DW(DW), .AW(AW), .NRP(NRP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_rdy     (rd_rdy),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .issue_rdy  (issue_rdy),
    .pend_cnt   (pend_cnt),
    .wb_err     (wb_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Model
  // ---------------------------------------------------------------------------
  function automatic logic [DW-1:0] m_rd_data(input int a);
    if (wb_en && int'(wb_addr) == a) return wb_data;
    return m_reg[a];
  endfunction

  function automatic logic m_rd_rdy(input int a);
    return (wb_en && int'(wb_addr) == a) || !m_busy[a];
  endfunction

  function automatic logic m_issue_rdy();
    return !m_busy[issue_addr] || (wb_en && wb_addr == issue_addr);
  endfunction

  function automatic int m_pend();
    int n = 0;
    for (int r = 0; r < DEPTH; r++) n += int'(m_busy[r]);
    return n;
  endfunction

  function automatic logic [DW-1:0] port_data(input int p);
    return rd_data[p*DW +: DW];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < DEPTH; r++) begin
      m_reg[r]  = '0;
      m_busy[r] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  // Apply one clock edge's worth of rules to the model using current inputs.
  task automatic model_edge();
    bit acc;
    acc = issue_en && m_issue_rdy();
    if (wb_en) begin
      if (!m_busy[wb_addr] && !(acc && issue_addr == wb_addr)) m_err = 1'b1;
      m_reg[wb_addr]  = wb_data;
      m_busy[wb_addr] = 1'b0;
    end
    if (acc) m_busy[issue_addr] = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_en    = 1'b0;
    issue_en = 1'b0;
  endtask

  task automatic set_rd(input int a0, input int a1, input int a2);
    rd_addr = {AW'(a2), AW'(a1), AW'(a0)};
  endtask

  task automatic do_reset();
    idle();
    wb_addr    = '0;
    wb_data    = '0;
    issue_addr = '0;
    rd_addr    = '0;
    rst_n      = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    wb_en = 1'b1; wb_addr = 4'd5; wb_data = 32'hDEADBEEF;
    issue_en = 1'b1; issue_addr = 4'd3;
    tick();
    idle();
    set_rd(5, 3, 0);
    @(negedge clk);
    n_tests++; if (port_data(0) !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL reset_preload_data: got %h expected %h", port_data(0), 32'hDEADBEEF); end
    n_tests++; if (pend_cnt !== 5'd1) begin n_fail++;
      $display("FAIL reset_preload_pend: got %0d expected 1", pend_cnt); end
    // Assert reset between edges with a live write-back on the read address.
    @(posedge clk); #3;
    wb_en = 1'b1; wb_addr = 4'd5; wb_data = 32'h0BADF00D;
    set_rd(5, 5, 5);
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int p = 0; p < NRP; p++) begin
      n_tests++; if (port_data(p) !== '0) begin n_fail++;
        $display("FAIL reset_rd_data[%0d]: got %h expected 0", p, port_data(p)); end
    end
    n_tests++; if (rd_rdy !== 3'b111) begin n_fail++;
      $display("FAIL reset_rd_rdy: got %b expected 111", rd_rdy); end
    n_tests++; if (issue_rdy !== 1'b1 || pend_cnt !== 5'd0 || wb_err !== 1'b0) begin n_fail++;
      $display("FAIL reset_ctrl: got rdy=%b pend=%0d err=%b expected 1/0/0",
               issue_rdy, pend_cnt, wb_err); end
    @(posedge clk); #1;
    idle();
    rst_n = 1'b1;
    set_rd(3, 5, 0);
    @(negedge clk);
    n_tests++; if (rd_rdy !== 3'b111 || port_data(1) !== '0) begin n_fail++;
      $display("FAIL reset_after: got rdy=%b d1=%h expected 111/0", rd_rdy, port_data(1)); end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    do_reset();
    issue_en = 1'b1; issue_addr = 4'd7;
    tick();
    idle();
    wb_en = 1'b1; wb_addr = 4'd7; wb_data = 32'h12345678;
    tick();
    idle();
    set_rd(7, 7, 2);
    @(negedge clk);
    n_tests++; if (port_data(0) !== 32'h12345678 || port_data(1) !== 32'h12345678) begin n_fail++;
      $display("FAIL wr_ports01: got %h %h expected 12345678", port_data(0), port_data(1)); end
    n_tests++; if (port_data(2) !== '0) begin n_fail++;
      $display("FAIL wr_port2: got %h expected 0", port_data(2)); end
    n_tests++; if (rd_rdy !== 3'b111 || wb_err !== 1'b0) begin n_fail++;
      $display("FAIL wr_rdy_err: got rdy=%b err=%b expected 111/0", rd_rdy, wb_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_bypass();
    do_reset();
    issue_en = 1'b1; issue_addr = 4'd9;
    tick();
    idle();
    wb_en = 1'b1; wb_addr = 4'd9; wb_data = 32'h0BAD0009;
    tick();
    idle();
    issue_en = 1'b1; issue_addr = 4'd9;
    tick();
    idle();
    set_rd(3, 9, 3);
    @(negedge clk);
    n_tests++; if (port_data(1) !== 32'h0BAD0009 || rd_rdy[1] !== 1'b0) begin n_fail++;
      $display("FAIL byp_before: got %h rdy=%b expected 0bad0009/0", port_data(1), rd_rdy[1]); end
    @(posedge clk); #1;
    wb_en = 1'b1; wb_addr = 4'd9; wb_data = 32'hA5A5A5A5;
    @(negedge clk);
    n_tests++; if (port_data(1) !== 32'hA5A5A5A5) begin n_fail++;
      $display("FAIL byp_data: got %h expected a5a5a5a5", port_data(1)); end
    n_tests++; if (rd_rdy !== 3'b111) begin n_fail++;
      $display("FAIL byp_rdy: got %b expected 111", rd_rdy); end
    tick();
    idle();
    set_rd(9, 9, 9);
    @(negedge clk);
    for (int p = 0; p < NRP; p++) begin
      n_tests++; if (port_data(p) !== 32'hA5A5A5A5) begin n_fail++;
        $display("FAIL byp_stored[%0d]: got %h expected a5a5a5a5", p, port_data(p)); end
    end
    n_tests++; if (pend_cnt !== 5'd0 || wb_err !== 1'b0) begin n_fail++;
      $display("FAIL byp_ctrl: got pend=%0d err=%b expected 0/0", pend_cnt, wb_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_raw();
    do_reset();
    issue_en = 1'b1; issue_addr = 4'd4;
    @(negedge clk);
    n_tests++; if (issue_rdy !== 1'b1) begin n_fail++;
      $display("FAIL raw_first_issue_rdy: got %b expected 1", issue_rdy); end
    tick();
    issue_en = 1'b0;
    set_rd(4, 4, 0);
    @(negedge clk);
    n_tests++; if (rd_rdy !== 3'b100) begin n_fail++;
      $display("FAIL raw_rdy: got %b expected 100", rd_rdy); end
    n_tests++; if (pend_cnt !== 5'd1 || issue_rdy !== 1'b0) begin n_fail++;
      $display("FAIL raw_busy: got pend=%0d issue_rdy=%b expected 1/0", pend_cnt, issue_rdy); end
    // A rejected issue held for a cycle must change nothing.
    @(posedge clk); #1;
    issue_en = 1'b1;
    tick();
    issue_en = 1'b0;
    @(negedge clk);
    n_tests++; if (pend_cnt !== 5'd1) begin n_fail++;
      $display("FAIL raw_reject_pend: got %0d expected 1", pend_cnt); end
    @(posedge clk); #1;
    wb_en = 1'b1; wb_addr = 4'd4; wb_data = 32'h55;
    @(negedge clk);
    n_tests++; if (rd_rdy !== 3'b111 || port_data(0) !== 32'h55) begin n_fail++;
      $display("FAIL raw_wb: got rdy=%b d0=%h expected 111/55", rd_rdy, port_data(0)); end
    tick();
    idle();
    n_tests++; if (pend_cnt !== 5'd0 || wb_err !== 1'b0) begin n_fail++;
      $display("FAIL raw_after_wb: got pend=%0d err=%b expected 0/0", pend_cnt, wb_err); end
  endtask

  task automatic test_same_addr();
    do_reset();
    issue_en = 1'b1; issue_addr = 4'd6;
    tick();
    wb_en = 1'b1; wb_addr = 4'd6; wb_data = 32'hCAFE0006;
    @(negedge clk);
    n_tests++; if (issue_rdy !== 1'b1) begin n_fail++;
      $display("FAIL same_issue_rdy: got %b expected 1", issue_rdy); end
    tick();
    idle();
    set_rd(6, 0, 6);
    @(negedge clk);
    n_tests++; if (pend_cnt !== 5'd1 || wb_err !== 1'b0) begin n_fail++;
      $display("FAIL same_ctrl: got pend=%0d err=%b expected 1/0", pend_cnt, wb_err); end
    n_tests++; if (rd_rdy !== 3'b010 || port_data(0) !== 32'hCAFE0006) begin n_fail++;
      $display("FAIL same_reg: got rdy=%b d0=%h expected 010/cafe0006", rd_rdy, port_data(0)); end
    @(posedge clk); #1;
  endtask

  task automatic test_error_fill();
    do_reset();
    n_tests++; if (wb_err !== 1'b0) begin n_fail++;
      $display("FAIL err_initial: got %b expected 0", wb_err); end
    wb_en = 1'b1; wb_addr = 4'd2; wb_data = 32'h00000222;
    tick();
    idle();
    set_rd(2, 2, 2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if (wb_err !== 1'b1 || port_data(0) !== 32'h222) begin n_fail++;
      $display("FAIL err_sticky: got err=%b d0=%h expected 1/222", wb_err, port_data(0)); end
    @(posedge clk); #1;
    for (int a = 0; a < DEPTH; a++) begin
      issue_en = 1'b1; issue_addr = AW'(a);
      tick();
    end
    idle();
    @(negedge clk);
    n_tests++; if (pend_cnt !== 5'd16) begin n_fail++;
      $display("FAIL fill_pend: got %0d expected 16", pend_cnt); end
    for (int a = 0; a < DEPTH; a++) begin
      issue_addr = AW'(a);
      @(negedge clk);
      n_tests++; if (issue_rdy !== 1'b0) begin n_fail++;
        $display("FAIL fill_issue_rdy[%0d]: got %b expected 0", a, issue_rdy); end
    end
    @(posedge clk); #1;
    for (int a = 0; a < DEPTH; a++) begin
      wb_en = 1'b1; wb_addr = AW'(a); wb_data = DW'(a);
      tick();
    end
    idle();
    @(negedge clk);
    n_tests++; if (pend_cnt !== 5'd0 || wb_err !== 1'b1) begin n_fail++;
      $display("FAIL drain: got pend=%0d err=%b expected 0/1", pend_cnt, wb_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit hold = 1'b0;
    int a;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      wb_en = ($urandom_range(0, 99) < 45);
      a = $urandom_range(0, DEPTH-1);
      // Mostly retire a pending register so the scoreboard keeps cycling.
      if ($urandom_range(0, 9) < 8) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (m_busy[(a + k) % DEPTH]) begin a = (a + k) % DEPTH; break; end
        end
      end
      wb_addr = AW'(a);
      wb_data = $urandom();
      if (!hold) begin
        issue_en   = ($urandom_range(0, 99) < 50);
        issue_addr = AW'($urandom_range(0, DEPTH-1));
      end
      for (int p = 0; p < NRP; p++) begin
        rd_addr[p*AW +: AW] = ($urandom_range(0, 3) == 0) ? wb_addr
                                                          : AW'($urandom_range(0, DEPTH-1));
      end
      @(negedge clk);
      for (int p = 0; p < NRP; p++) begin
        n_tests++; if (port_data(p) !== m_rd_data(int'(rd_addr[p*AW +: AW]))) begin n_fail++;
          $display("FAIL rnd_data cyc=%0d port=%0d: got %h expected %h", cyc, p,
                   port_data(p), m_rd_data(int'(rd_addr[p*AW +: AW]))); end
        n_tests++; if (rd_rdy[p] !== m_rd_rdy(int'(rd_addr[p*AW +: AW]))) begin n_fail++;
          $display("FAIL rnd_rdy cyc=%0d port=%0d: got %b expected %b", cyc, p,
                   rd_rdy[p], m_rd_rdy(int'(rd_addr[p*AW +: AW]))); end
      end
      n_tests++; if (issue_rdy !== m_issue_rdy()) begin n_fail++;
        $display("FAIL rnd_issue_rdy cyc=%0d: got %b expected %b", cyc, issue_rdy, m_issue_rdy()); end
      n_tests++; if (int'(pend_cnt) !== m_pend()) begin n_fail++;
        $display("FAIL rnd_pend cyc=%0d: got %0d expected %0d", cyc, pend_cnt, m_pend()); end
      n_tests++; if (wb_err !== m_err) begin n_fail++;
        $display("FAIL rnd_wb_err cyc=%0d: got %b expected %b", cyc, wb_err, m_err); end
      hold = issue_en && !m_issue_rdy();
      tick();
    end
    idle();
  endtask

  initial begin
    rst_n      = 1'b0;
    wb_en      = 1'b0;
    wb_addr    = '0;
    wb_data    = '0;
    issue_en   = 1'b0;
    issue_addr = '0;
    rd_addr    = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    test_reset();
    test_write_read();
    test_bypass();
    test_raw();
    test_same_addr();
    test_error_fill();
    test_random();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
